// File: rtl/tmds_serializer_10to1_if.sv
// rtl/tmds_serializer_10to1_if.sv - parallel-in / serial-out bundle for the 10:1 TMDS serializer
//
// Purpose: groups the lock input, the parallel word bus and the serial,
//          load and synchronized-reset outputs of tmds_serializer_10to1.
// Signals:
//   i_clk_lock  upstream clock-generator lock (low acts as reset)
//   i_data      10*CHANNELS parallel words, lane n = [10n+9:10n]
//   o_data      CHANNELS serial bits, one per lane
//   o_load      high in the cycle whose closing edge samples i_data
//   o_rst       synchronized reset for neighbouring logic
// Modports: master = word source / consumer side, slave = serializer.
`timescale 1ns/1ps

interface tmds_serializer_10to1_if #(
  parameter int CHANNELS = 3
);
  logic                      i_clk_lock;
  logic [10*CHANNELS-1:0]    i_data;
  logic [CHANNELS-1:0]       o_data;
  logic                      o_load;
  logic                      o_rst;

  modport master (
    output i_clk_lock,
    output i_data,
    input  o_data,
    input  o_load,
    input  o_rst
  );

  modport slave (
    input  i_clk_lock,
    input  i_data,
    output o_data,
    output o_load,
    output o_rst
  );
endinterface

// File: rtl/tmds_serializer_10to1.sv
// rtl/tmds_serializer_10to1.sv - 10:1 multi-lane TMDS serializer with reset synchronizer
//
// Purpose: serializes CHANNELS parallel 10-bit words onto CHANNELS serial
//          lanes at the bit-rate clock. A shared 0..9 counter frames the
//          words so every lane loads on the same edge and stays bit-aligned.
// Parameters:
//   CHANNELS     number of lanes, 1-8
//   SYNC_STAGES  reset synchronizer depth, 2-4
// Ports:
//   i_clk        bit-rate clock, rising edge
//   i_rst        asynchronous active-high reset
//   bus          tmds_serializer_10to1_if.slave (i_clk_lock, i_data,
//                o_data, o_load, o_rst)
// Configuration:
//   SER_MSB_FIRST_EN  when defined, bit 9 of each word is sent first;
//                     otherwise bit 0 is sent first. Timing is identical.
`timescale 1ns/1ps

module tmds_serializer_10to1 #(
  parameter int CHANNELS    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  tmds_serializer_10to1_if.slave  bus
);

  // Reset request: explicit reset or loss of upstream clock lock.
  logic rst_req;
  assign rst_req = i_rst | ~bus.i_clk_lock;

  // Asserts immediately via async set; releases after SYNC_STAGES edges
  // by shifting zeros through. A new request mid-countdown reloads all ones.
  logic [SYNC_STAGES-1:0] rst_chain;

  always_ff @(posedge i_clk or posedge rst_req) begin
    if (rst_req) begin
      rst_chain <= '1;
    end else begin
      rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  logic rst_sync;
  assign rst_sync  = rst_chain[SYNC_STAGES-1];
  assign bus.o_rst = rst_sync;

  // Word framing counter. Parked at 9 in reset so the first edge after
  // release is a load edge and framing always restarts on a word boundary.
  logic [3:0] bit_cnt;

  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) begin
      bit_cnt <= 4'd9;
    end else if (bit_cnt == 4'd9) begin
      bit_cnt <= 4'd0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  logic load;
  assign load       = (bit_cnt == 4'd9) & ~rst_sync;
  assign bus.o_load = load;

  // Per-lane shift registers. The serial output is the shift register's
  // end bit itself, so o_data is a flop output and clears asynchronously
  // together with the register when rst_sync rises.
  genvar lane;
  generate
    for (lane = 0; lane < CHANNELS; lane++) begin : g_lane
      logic [9:0] shreg;

      always_ff @(posedge i_clk or posedge rst_sync) begin
        if (rst_sync) begin
          shreg <= 10'd0;
        end else if (load) begin
          shreg <= bus.i_data[10*lane +: 10];
        end else begin
`ifdef SER_MSB_FIRST_EN
          shreg <= {shreg[8:0], 1'b0};
`else
          shreg <= {1'b0, shreg[9:1]};
`endif
        end
      end

`ifdef SER_MSB_FIRST_EN
      assign bus.o_data[lane] = shreg[9];
`else
      assign bus.o_data[lane] = shreg[0];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_tmds_serializer_10to1.sv
// tb/tb_tmds_serializer_10to1.sv - directed self-checking bench for tmds_serializer_10to1
`timescale 1ns/1ps

module tb_tmds_serializer_10to1;

  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  tmds_serializer_10to1_if #(.CHANNELS(CH)) bus ();

  tmds_serializer_10to1 #(
    .CHANNELS    (CH),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected serial bit k (0 = first after the load edge) of word w.
  function automatic logic exp_bit(input logic [9:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
    return w[9-k];
`else
    return w[k];
`endif
  endfunction

  // Two edges after reset release: edge 1 keeps o_rst high, edge 2 drops it
  // and o_load must then be high with o_data still zero.
  task automatic release_and_check(input string name);
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL %s edge1 o_rst: got %b expected 1", name, bus.o_rst);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL %s edge2 o_rst: got %b expected 0", name, bus.o_rst);
    end
    n_checks++;
    if (bus.o_load !== 1'b1) begin
      n_fail++;
      $display("FAIL %s edge2 o_load: got %b expected 1", name, bus.o_load);
    end
    n_checks++;
    if (bus.o_data !== 3'b000) begin
      n_fail++;
      $display("FAIL %s edge2 o_data: got %b expected 000", name, bus.o_data);
    end
  endtask

  // Call while o_load is high (before the load edge); checks nwords words.
  task automatic run_words(input logic [29:0] w, input int nwords, input string name);
    bus.i_data = w;
    @(posedge clk);
    for (int wi = 0; wi < nwords; wi++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        for (int n = 0; n < CH; n++) begin
          n_checks++;
          if (bus.o_data[n] !== exp_bit(w[10*n +: 10], k)) begin
            n_fail++;
            $display("FAIL %s lane%0d word%0d bit%0d: got %b expected %b",
                     name, n, wi, k, bus.o_data[n], exp_bit(w[10*n +: 10], k));
          end
        end
        n_checks++;
        if (bus.o_load !== (k == 9)) begin
          n_fail++;
          $display("FAIL %s o_load word%0d bit%0d: got %b expected %b",
                   name, wi, k, bus.o_load, (k == 9));
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.i_clk_lock = 1'b1;
    bus.i_data     = {10'b0000011111, 10'b1001011001, 10'b0110100110};
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset o_rst: got %b expected 1", bus.o_rst);
    end
    n_checks++;
    if (bus.o_data !== 3'b000) begin
      n_fail++;
      $display("FAIL reset o_data: got %b expected 000", bus.o_data);
    end
    n_checks++;
    if (bus.o_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset o_load: got %b expected 0", bus.o_load);
    end
    #1 rst = 1'b0;
    release_and_check("reset_release");
  endtask

  task automatic test_patterns();
    run_words({10'b0000011111, 10'b1001011001, 10'b0110100110}, 2, "patterns");
  endtask

  task automatic test_back_to_back();
    run_words({10'b0000000000, 10'b1010101010, 10'b1111111111}, 2, "constants");
    run_words({10'b1111111111, 10'b0000000000, 10'b0101010101}, 1, "swap");
  endtask

  task automatic test_data_change();
    logic [29:0] wa, wb;
    wa = {10'b1100110011, 10'b0011110000, 10'b1000000001};
    wb = {10'b0101101010, 10'b1111000011, 10'b0111111110};
    bus.i_data = wa;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int n = 0; n < CH; n++) begin
        n_checks++;
        if (bus.o_data[n] !== exp_bit(wa[10*n +: 10], k)) begin
          n_fail++;
          $display("FAIL data_change lane%0d bit%0d: got %b expected %b",
                   n, k, bus.o_data[n], exp_bit(wa[10*n +: 10], k));
        end
      end
      if (k == 0) begin
        @(posedge clk); #1;
        bus.i_data = wb;
      end
    end
    run_words(wb, 1, "data_change_new");
  endtask

  task automatic test_lock_loss();
    bus.i_data = 30'h3FFF_FFFF;
    @(posedge clk);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.o_data !== 3'b111) begin
      n_fail++;
      $display("FAIL lock_pre o_data: got %b expected 111", bus.o_data);
    end
    #1 bus.i_clk_lock = 1'b0;
    #1;
    n_checks++;
    if (bus.o_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_drop o_rst: got %b expected 1", bus.o_rst);
    end
    n_checks++;
    if (bus.o_data !== 3'b000) begin
      n_fail++;
      $display("FAIL lock_drop o_data: got %b expected 000", bus.o_data);
    end
    #10;
    n_checks++;
    if (bus.o_rst !== 1'b1 || bus.o_load !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_hold o_rst/o_load: got %b/%b expected 1/0", bus.o_rst, bus.o_load);
    end
    #12 bus.i_clk_lock = 1'b1;
    release_and_check("lock_release");
    run_words({10'b0000011111, 10'b1001011001, 10'b0110100110}, 1, "lock_fresh");
  endtask

  task automatic test_async_release();
    @(negedge clk);
    #2 rst = 1'b1;
    #10;
    n_checks++;
    if (bus.o_rst !== 1'b1 || bus.o_data !== 3'b000) begin
      n_fail++;
      $display("FAIL async_hold o_rst/o_data: got %b/%b expected 1/000", bus.o_rst, bus.o_data);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL async_release glitch o_rst: got %b expected 1", bus.o_rst);
    end
    release_and_check("async_release");
    run_words({10'b1010101010, 10'b1111111111, 10'b0110100110}, 1, "async_fresh");
  endtask

  initial begin
    bus.i_clk_lock = 1'b1;
    bus.i_data     = '0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_data_change();
    test_lock_loss();
    test_async_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_serializer_10to1.md
TMDS_SERIALIZER_10TO1 -- requirements
Module: tmds_serializer_10to1

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent 10-bit lanes, legal range 1-8.
REQ-002 Parameter SYNC_STAGES, default 2: reset synchronizer depth, legal range 2-4.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  bit-rate clock; all registers use its rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_clk_lock  input  1  upstream clock-generator lock; low is treated as reset.
REQ-007 i_data  input  10*CHANNELS  parallel words; lane n is bits [10n+9:10n].
REQ-008 o_data  output  CHANNELS  serial bit per lane, registered.
REQ-009 o_load  output  1  high in the cycle whose closing edge samples i_data.
REQ-010 o_rst  output  1  synchronized reset, for use by neighbouring logic.

Function
REQ-011 Reset request = i_rst OR NOT i_clk_lock.
REQ-012 o_rst SHALL assert asynchronously, with no clock edge, when the reset request rises.
REQ-013 o_rst SHALL deassert on the SYNC_STAGES-th rising edge after the reset request falls, through a SYNC_STAGES-deep flop chain that shifts in 0.
REQ-014 If the request reasserts during the deassert countdown, the chain SHALL reload to all-ones immediately.
REQ-015 A 4-bit counter SHALL cycle 0..9 and wrap from 9 to 0; it is shared by all lanes.
REQ-016 o_load = (counter == 9) AND NOT o_rst.
REQ-017 On each rising edge with o_load high, every lane's 10-bit shift register SHALL load its i_data word.
REQ-018 On every other edge, each shift register SHALL shift one position toward the output end.
REQ-019 o_data[n] = output end of lane n's shift register.
REQ-020 Bit order SHALL be LSB first: data bit 0 is on o_data for the first cycle after the load edge and bit 9 for the tenth.
REQ-021 Word period SHALL be exactly 10 cycles with no gaps; a new word loads every 10th edge.
REQ-022 i_data SHALL only be sampled on load edges; changes between load edges have no effect.
REQ-023 All lanes SHALL be bit-aligned, sharing the same load edge.

Reset
REQ-024 While o_rst is high: counter = 9, all shift registers = 0, o_data = all zeros, o_load = 0.
REQ-025 First edge after o_rst falls SHALL load i_data, so o_load is high during the first cycle after o_rst deasserts.
REQ-026 Reset or lock loss mid-word SHALL drop o_data to 0 asynchronously and abandon the partial word; no resume of the old word.
REQ-027 Each deassertion SHALL restart framing at a word boundary.

Configuration
REQ-028 Macro SER_MSB_FIRST_EN.
REQ-029 If SER_MSB_FIRST_EN is defined: bit 9 is emitted first and bit 0 last; all timing is unchanged.
REQ-030 If SER_MSB_FIRST_EN is not defined: LSB-first order per REQ-020.

Verification
REQ-031 i_rst pulse 1.5-20 ns with i_clk_lock=1 -> o_rst high within the pulse, low on the 2nd edge after release, o_load high the following cycle, o_data 0 throughout.
REQ-032 Lane 0 = 10'b0110100110 -> o_data[0] sequence 0,1,1,0,0,1,0,1,1,0 repeating every 10 cycles; lane 1 = 10'b1001011001 -> 1,0,0,1,1,0,1,0,0,1.
REQ-033 Lanes = 10'b1111111111 / 10'b1010101010 / 10'b0000000000 -> constant 1 / alternating 0,1 / constant 0, all with no gap at word boundaries.
REQ-034 i_clk_lock dropped mid-word for 23 ns -> o_data and o_rst respond without an edge (o_data to 0, o_rst to 1); recovery per REQ-031 with a fresh word boundary.
REQ-035 i_data changed one cycle after a load edge -> current word completes unchanged; new word appears after the next load.
REQ-036 i_rst asserted, then released between clock edges -> no glitch on o_rst deassert; deassert is synchronous to i_clk.
